// File: rtl/sys_array_scratchpad_pkg.sv
// sys_array_pkg: shared types, limits and helpers for the systolic-array scratchpad
package sys_array_pkg;

    typedef enum logic {
        HOST_IDLE = 1'b0,
        HOST_RESP = 1'b1
    } host_state_t;

    localparam int READ_LATENCY_MAX = 1;

    function automatic logic in_range(input logic [31:0] addr, input int unsigned depth);
        return addr < depth;
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? '1 : s[31:0];
    endfunction

endpackage

// File: rtl/sys_array_scratchpad_if.sv
// sys_array_scratchpad_if: host load/store handshake between a host master and the scratchpad
interface sys_array_scratchpad_if #(
    parameter int BITWIDTH = 16
);
    logic                host_req_valid;
    logic                host_req_ready;
    logic                host_req_write;
    logic [BITWIDTH-1:0] host_req_addr;
    logic [BITWIDTH-1:0] host_req_wdata;
    logic                host_resp_valid;
    logic [BITWIDTH-1:0] host_resp_rdata;

    modport master (
        output host_req_valid, host_req_write, host_req_addr, host_req_wdata,
        input  host_req_ready, host_resp_valid, host_resp_rdata
    );

    modport slave (
        input  host_req_valid, host_req_write, host_req_addr, host_req_wdata,
        output host_req_ready, host_resp_valid, host_resp_rdata
    );
endinterface

// File: rtl/sys_array_scratchpad_read_lane.sv
// scratchpad_read_lane: one base address + valid into TILEUNITS range-checked words, optionally registered
module scratchpad_read_lane
    import sys_array_pkg::*;
#(
    parameter int BITWIDTH     = 16,
    parameter int TILEUNITS    = 2,
    parameter int DEPTH        = 256,
    parameter int READ_LATENCY = 1
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [BITWIDTH-1:0]                 i_mem [DEPTH],
    input  logic [BITWIDTH-1:0]                 i_addr,
    input  logic                                i_valid,
    output logic [TILEUNITS-1:0][BITWIDTH-1:0]  o_data,
    output logic                                o_oor
);
    localparam int AW = $clog2(DEPTH);

    logic [TILEUNITS-1:0][BITWIDTH-1:0] w_data;
    logic [TILEUNITS-1:0]               w_oor;

    for (genvar j = 0; j < TILEUNITS; j++) begin : g_word
        logic [31:0] w_a;
        assign w_a       = 32'(i_addr) + 32'(j);
        assign w_data[j] = (i_valid && in_range(w_a, DEPTH)) ? i_mem[AW'(w_a)] : '0;
        assign w_oor[j]  = i_valid && !in_range(w_a, DEPTH);
    end

    assign o_oor = |w_oor;

    if (READ_LATENCY == 1) begin : g_reg
        logic [TILEUNITS-1:0][BITWIDTH-1:0] r_data;
        // register the gathered words; a non-valid lane registers zeros
        always_ff @(posedge clock) begin
            r_data <= reset ? '0 : w_data;
        end
        assign o_data = r_data;
    end else begin : g_comb
        assign o_data = w_data;
    end
endmodule

// File: rtl/sys_array_scratchpad.sv
// sys_array_scratchpad: tile scratchpad serving A/D/B reads, C writes and a host port; optional SCRATCHPAD_STATS_EN counters
module sys_array_scratchpad
    import sys_array_pkg::*;
#(
    parameter int BITWIDTH     = 16,
    parameter int MESHUNITS    = 2,
    parameter int TILEUNITS    = 2,
    parameter int DEPTH        = 256,
    parameter int READ_LATENCY = 1
) (
    input  logic                                                 clock,
    input  logic                                                 reset,
    input  logic        [MESHUNITS-1:0][BITWIDTH-1:0]             A_row_read_addrs,
    input  logic        [MESHUNITS-1:0][BITWIDTH-1:0]             D_col_read_addrs,
    input  logic        [MESHUNITS-1:0][BITWIDTH-1:0]             B_col_read_addrs,
    input  logic        [MESHUNITS-1:0]                           A_read_valid,
    input  logic        [MESHUNITS-1:0]                           D_read_valid,
    input  logic        [MESHUNITS-1:0]                           B_read_valid,
    output logic signed [MESHUNITS-1:0][TILEUNITS-1:0][BITWIDTH-1:0] A,
    output logic signed [MESHUNITS-1:0][TILEUNITS-1:0][BITWIDTH-1:0] D,
    output logic signed [MESHUNITS-1:0][TILEUNITS-1:0][BITWIDTH-1:0] B,
    input  logic        [MESHUNITS-1:0][TILEUNITS-1:0][BITWIDTH-1:0] C,
    input  logic        [MESHUNITS-1:0][BITWIDTH-1:0]             C_col_write_addrs,
    input  logic        [MESHUNITS-1:0]                           C_write_valid,
    sys_array_scratchpad_if.slave                                 host,
    output logic                                                  range_err
`ifdef SCRATCHPAD_STATS_EN
    ,
    output logic [31:0]                                           stat_reads,
    output logic [31:0]                                           stat_writes,
    output logic [31:0]                                           stat_stalls
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int NL = 3 * MESHUNITS;

    if (READ_LATENCY < 0 || READ_LATENCY > READ_LATENCY_MAX || DEPTH > (1 << BITWIDTH)) begin : g_bad_cfg
        $error("sys_array_scratchpad: illegal READ_LATENCY or DEPTH");
    end

    logic [BITWIDTH-1:0]                        r_mem [DEPTH];
    host_state_t                                r_state;
    logic [NL-1:0][BITWIDTH-1:0]                w_raddr;
    logic [NL-1:0]                              w_rvalid;
    logic [NL-1:0]                              w_roor;
    logic [NL-1:0][TILEUNITS-1:0][BITWIDTH-1:0] w_rdata;
    logic                                       w_busy;
    logic                                       w_fire;
    logic                                       w_host_in;
    logic [AW-1:0]                              w_host_idx;
    logic                                       w_c_oor;

    assign w_raddr  = {B_col_read_addrs, D_col_read_addrs, A_row_read_addrs};
    assign w_rvalid = {B_read_valid, D_read_valid, A_read_valid};
    assign {B, D, A} = w_rdata;

    for (genvar k = 0; k < NL; k++) begin : g_lane
        scratchpad_read_lane #(
            .BITWIDTH    (BITWIDTH),
            .TILEUNITS   (TILEUNITS),
            .DEPTH       (DEPTH),
            .READ_LATENCY(READ_LATENCY)
        ) u_lane (
            .clock  (clock),
            .reset  (reset),
            .i_mem  (r_mem),
            .i_addr (w_raddr[k]),
            .i_valid(w_rvalid[k]),
            .o_data (w_rdata[k]),
            .o_oor  (w_roor[k])
        );
    end

    assign w_busy               = |w_rvalid || |C_write_valid;
    assign host.host_req_ready  = !w_busy && !reset;
    assign w_fire               = host.host_req_valid && host.host_req_ready;
    assign w_host_in            = in_range(32'(host.host_req_addr), DEPTH);
    assign w_host_idx           = AW'(host.host_req_addr);
    assign host.host_resp_valid = r_state == HOST_RESP;

    // any valid C lane word that falls past the end of the scratchpad
    always_comb begin
        w_c_oor = 1'b0;
        for (int i = 0; i < MESHUNITS; i++)
            for (int j = 0; j < TILEUNITS; j++)
                w_c_oor = w_c_oor | (C_write_valid[i] && !in_range(32'(C_col_write_addrs[i]) + 32'(j), DEPTH));
    end

    // memory update: reset clears, C lanes in ascending order so the higher lane wins, then host stores
    always_ff @(posedge clock) begin
        if (reset) begin
            r_mem <= '{default: '0};
        end else begin
            for (int i = 0; i < MESHUNITS; i++)
                for (int j = 0; j < TILEUNITS; j++)
                    if (C_write_valid[i] && in_range(32'(C_col_write_addrs[i]) + 32'(j), DEPTH))
                        r_mem[AW'(32'(C_col_write_addrs[i]) + 32'(j))] <= C[i][j];
            if (w_fire && host.host_req_write && w_host_in)
                r_mem[w_host_idx] <= host.host_req_wdata;
        end
    end

    // host FSM: RESP for exactly the cycle after each accepted load, capturing pre-write data
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state              <= HOST_IDLE;
            host.host_resp_rdata <= '0;
        end else if (w_fire && !host.host_req_write) begin
            r_state              <= HOST_RESP;
            host.host_resp_rdata <= w_host_in ? r_mem[w_host_idx] : '0;
        end else begin
            r_state              <= HOST_IDLE;
        end
    end

    // sticky out-of-range flag from reads, C writes and host accesses
    always_ff @(posedge clock) begin
        range_err <= reset ? 1'b0 : range_err | (|w_roor) | w_c_oor | (w_fire && !w_host_in);
    end

`ifdef SCRATCHPAD_STATS_EN
    // saturating activity counters
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_reads  <= '0;
            stat_writes <= '0;
            stat_stalls <= '0;
        end else begin
            stat_reads  <= sat_add(stat_reads, 32'($countones(w_rvalid)));
            stat_writes <= sat_add(stat_writes, 32'($countones(C_write_valid)) + 32'(w_fire && host.host_req_write));
            stat_stalls <= sat_add(stat_stalls, 32'(host.host_req_valid && !host.host_req_ready));
        end
    end
`endif
endmodule

// File: tb/tb_sys_array_scratchpad.sv
// tb_sys_array_scratchpad: directed plus randomized checks against a behavioural scratchpad model
module tb_sys_array_scratchpad;
    localparam int BW = 16;
    localparam int M = 2;
    localparam int T = 2;
    localparam int DEPTH = 256;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic        [M-1:0][BW-1:0]        a_addr, d_addr, b_addr, c_addr;
    logic        [M-1:0]                a_v, d_v, b_v, c_v;
    logic signed [M-1:0][T-1:0][BW-1:0] A, D, B;
    logic        [M-1:0][T-1:0][BW-1:0] C;
    logic                               range_err;
`ifdef SCRATCHPAD_STATS_EN
    logic [31:0] stat_reads, stat_writes, stat_stalls;
`endif

    sys_array_scratchpad_if #(.BITWIDTH(BW)) host ();

    sys_array_scratchpad #(
        .BITWIDTH(BW), .MESHUNITS(M), .TILEUNITS(T), .DEPTH(DEPTH), .READ_LATENCY(1)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .A_row_read_addrs (a_addr),
        .D_col_read_addrs (d_addr),
        .B_col_read_addrs (b_addr),
        .A_read_valid     (a_v),
        .D_read_valid     (d_v),
        .B_read_valid     (b_v),
        .A                (A),
        .D                (D),
        .B                (B),
        .C                (C),
        .C_col_write_addrs(c_addr),
        .C_write_valid    (c_v),
        .host             (host),
        .range_err        (range_err)
`ifdef SCRATCHPAD_STATS_EN
        ,
        .stat_reads       (stat_reads),
        .stat_writes      (stat_writes),
        .stat_stalls      (stat_stalls)
`endif
    );

    int n_chk = 0;
    int n_pass = 0;

    logic [BW-1:0] mem [DEPTH];
    logic [BW-1:0] e_rd [3][M][T];
    logic          e_rv, e_err;
    logic [BW-1:0] e_rdata;
    int unsigned   e_reads, e_writes, e_stalls;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic hreq(input logic v, input logic w, input logic [BW-1:0] a, input logic [BW-1:0] wd);
        host.host_req_valid = v;
        host.host_req_write = w;
        host.host_req_addr  = a;
        host.host_req_wdata = wd;
    endtask

    function automatic logic [BW-1:0] rd_out(input int op, input int i, input int j);
        return op == 0 ? A[i][j] : op == 1 ? D[i][j] : B[i][j];
    endfunction

    task automatic cyc();
        logic busy, rdy, fire, v;
        logic [BW-1:0] a;
        int w;
        #1;
        busy = |{a_v, d_v, b_v, c_v};
        rdy = !busy && !reset;
        chk("ready", 64'(host.host_req_ready), 64'(rdy));
        for (int op = 0; op < 3; op++)
            for (int i = 0; i < M; i++)
                for (int j = 0; j < T; j++) begin
                    a = op == 0 ? a_addr[i] : op == 1 ? d_addr[i] : b_addr[i];
                    v = op == 0 ? a_v[i] : op == 1 ? d_v[i] : b_v[i];
                    w = int'(a) + j;
                    e_rd[op][i][j] = (v && w < DEPTH) ? mem[w] : '0;
                    if (v && w >= DEPTH) e_err = 1'b1;
                end
        e_reads += $countones({a_v, d_v, b_v});
        fire = host.host_req_valid && rdy;
        if (host.host_req_valid && !rdy) e_stalls++;
        e_rv = fire && !host.host_req_write;
        if (e_rv) e_rdata = host.host_req_addr < DEPTH ? mem[host.host_req_addr] : '0;
        if (fire && host.host_req_addr >= DEPTH) e_err = 1'b1;
        for (int i = 0; i < M; i++)
            for (int j = 0; j < T; j++)
                if (c_v[i]) begin
                    w = int'(c_addr[i]) + j;
                    if (w < DEPTH) mem[w] = C[i][j];
                    else e_err = 1'b1;
                end
        e_writes += $countones(c_v);
        if (fire && host.host_req_write) begin
            e_writes++;
            if (host.host_req_addr < DEPTH) mem[host.host_req_addr] = host.host_req_wdata;
        end
        if (reset) begin
            foreach (mem[k]) mem[k] = '0;
            for (int op = 0; op < 3; op++)
                for (int i = 0; i < M; i++)
                    for (int j = 0; j < T; j++) e_rd[op][i][j] = '0;
            e_rv = 1'b0;
            e_rdata = '0;
            e_err = 1'b0;
            e_reads = 0;
            e_writes = 0;
            e_stalls = 0;
        end
        @(posedge clock);
        #1;
        for (int op = 0; op < 3; op++)
            for (int i = 0; i < M; i++)
                for (int j = 0; j < T; j++)
                    chk($sformatf("rd%0d_%0d_%0d", op, i, j), 64'(rd_out(op, i, j)), 64'(e_rd[op][i][j]));
        chk("resp_valid", 64'(host.host_resp_valid), 64'(e_rv));
        if (e_rv) chk("resp_rdata", 64'(host.host_resp_rdata), 64'(e_rdata));
        chk("range_err", 64'(range_err), 64'(e_err));
`ifdef SCRATCHPAD_STATS_EN
        chk("stat_reads", 64'(stat_reads), 64'(e_reads));
        chk("stat_writes", 64'(stat_writes), 64'(e_writes));
        chk("stat_stalls", 64'(stat_stalls), 64'(e_stalls));
`endif
    endtask

    task automatic idle_array();
        a_v = '0; d_v = '0; b_v = '0; c_v = '0;
    endtask

    initial begin
        foreach (mem[k]) mem[k] = '0;
        e_rv = 1'b0; e_err = 1'b0; e_rdata = '0;
        e_reads = 0; e_writes = 0; e_stalls = 0;
        a_addr = '0; d_addr = '0; b_addr = '0; c_addr = '0; C = '0;
        idle_array();
        hreq(1'b0, 1'b0, '0, '0);
        reset = 1'b1;
        cyc();
        cyc();
        chk("reset_resp_rdata", 64'(host.host_resp_rdata), 64'(0));
        reset = 1'b0;

        for (int k = 0; k < 16; k++) begin
            hreq(1'b1, 1'b1, BW'(k), BW'(k + 100));
            cyc();
        end
        hreq(1'b1, 1'b0, 16'd5, '0);
        cyc();
        chk("load5_valid", 64'(host.host_resp_valid), 64'(1));
        chk("load5_data", 64'(host.host_resp_rdata), 64'(105));
        hreq(1'b0, 1'b0, '0, '0);
        cyc();

        a_v = 2'b10;
        a_addr[1] = 16'd4;
        cyc();
        chk("a10", 64'(A[1][0]), 64'(104));
        chk("a11", 64'(A[1][1]), 64'(105));
        chk("a00", 64'(A[0][0]), 64'(0));
        idle_array();

        c_v = 2'b11;
        c_addr[0] = 16'd8;
        c_addr[1] = 16'd8;
        C[0][0] = 16'd7;
        C[1][0] = 16'd9;
        C[0][1] = 16'd1;
        C[1][1] = 16'd2;
        cyc();
        idle_array();
        hreq(1'b1, 1'b0, 16'd8, '0);
        cyc();
        chk("collide8", 64'(host.host_resp_rdata), 64'(9));

        hreq(1'b1, 1'b1, 16'd20, 16'h0055);
        d_v = 2'b01;
        d_addr[0] = 16'd30;
        for (int n = 0; n < 3; n++) begin
            #1;
            chk("stall_ready", 64'(host.host_req_ready), 64'(0));
            cyc();
        end
        idle_array();
        cyc();
        hreq(1'b1, 1'b0, 16'd20, '0);
        cyc();
        chk("stall_commit", 64'(host.host_resp_rdata), 64'(16'h0055));

        hreq(1'b1, 1'b1, 16'd255, 16'h1234);
        cyc();
        hreq(1'b0, 1'b0, '0, '0);
        b_v = 2'b01;
        b_addr[0] = 16'd255;
        cyc();
        chk("oor_b0", 64'(B[0][0]), 64'(16'h1234));
        chk("oor_b1", 64'(B[0][1]), 64'(0));
        chk("oor_err", 64'(range_err), 64'(1));
        idle_array();
        cyc();
        chk("oor_sticky", 64'(range_err), 64'(1));

        hreq(1'b1, 1'b0, 16'd5, '0);
        cyc();
        hreq(1'b0, 1'b0, '0, '0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("rst_resp_valid", 64'(host.host_resp_valid), 64'(0));
        chk("rst_err", 64'(range_err), 64'(0));
        hreq(1'b1, 1'b0, 16'd5, '0);
        cyc();
        chk("rst_mem5", 64'(host.host_resp_rdata), 64'(0));

        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < M; i++) begin
                a_v[i] = $urandom_range(0, 7) == 0;
                d_v[i] = $urandom_range(0, 7) == 0;
                b_v[i] = $urandom_range(0, 7) == 0;
                c_v[i] = $urandom_range(0, 5) == 0;
                a_addr[i] = BW'($urandom_range(0, DEPTH + 2));
                d_addr[i] = BW'($urandom_range(0, DEPTH + 2));
                b_addr[i] = BW'($urandom_range(0, DEPTH + 2));
                c_addr[i] = BW'($urandom_range(DEPTH - 40, DEPTH + 2));
                for (int j = 0; j < T; j++) C[i][j] = BW'($urandom);
            end
            hreq($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 BW'($urandom_range(DEPTH - 40, DEPTH + 1)), BW'($urandom));
            reset = $urandom_range(0, 99) == 0;
            cyc();
        end
        reset = 1'b0;
        idle_array();
        hreq(1'b0, 1'b0, '0, '0);
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sys_array_scratchpad.md
Name: sys_array_scratchpad

Overview:
- Tile scratchpad memory that serves as the responder for the systolic-array controller's memory interface.
- Read side: serves the per-lane A row, D col and B col read requests (address + valid) and returns TILEUNITS consecutive words per lane.
- Write side: accepts the per-lane C column writes.
- A host load/store port with a valid/ready handshake fills and drains the scratchpad when the array is idle.

Parameters:
- BITWIDTH, 16, word width and address width.
- MESHUNITS, 2, number of request lanes per operand.
- TILEUNITS, 2, words returned or written per lane request.
- DEPTH, 256, scratchpad size in words; must be ≤ 2^BITWIDTH.
- READ_LATENCY, 1, array read latency in cycles; legal values are 0 (combinational) and 1 (registered).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- A_row_read_addrs / D_col_read_addrs / B_col_read_addrs  in  BITWIDTH x MESHUNITS  per-lane base word address
- A_read_valid / D_read_valid / B_read_valid  in  1 x MESHUNITS  per-lane read request
- A / D / B  out  signed BITWIDTH x MESHUNITS x TILEUNITS  read data
- C  in  BITWIDTH x MESHUNITS x TILEUNITS  write data
- C_col_write_addrs  in  BITWIDTH x MESHUNITS  per-lane write base address
- C_write_valid  in  1 x MESHUNITS  per-lane write enable
- host_req_valid  in  1  host request
- host_req_ready  out  1  host request accepted this cycle
- host_req_write  in  1  1 = store, 0 = load
- host_req_addr  in  BITWIDTH  host word address
- host_req_wdata  in  BITWIDTH  host store data
- host_resp_valid  out  1  load data valid
- host_resp_rdata  out  BITWIDTH  load data
- range_err  out  1  sticky out-of-range flag

Behaviour:
- Clocking and reset: one clock, `clock`. Reset is synchronous, active-high, named `reset`.
- Reset values:
  - All memory words are 0.
  - A, D and B are 0.
  - host_resp_valid and host_resp_rdata are 0.
  - range_err is 0.
- Array reads:
  - When lane i of operand X is valid, X[i][j] = mem[addr_i + j] for j = 0..TILEUNITS-1.
  - READ_LATENCY = 1: data appears on the cycle after the request. The output holds 0 on the cycle after a non-valid lane.
  - READ_LATENCY = 0: data is combinational from the current request. A non-valid lane outputs 0.
- Array writes: when C_write_valid[i] is high, mem[C_col_write_addrs[i] + j] <= C[i][j] at the clock edge.
- Write collision: if two lanes write the same word in the same cycle, the higher lane index wins.
- Read/write to the same word in the same cycle:
  - READ_LATENCY = 1 returns the old data (read-before-write).
  - READ_LATENCY = 0 also returns the old data; there is no forwarding.
- Out of range (addr + j ≥ DEPTH):
  - That word reads as 0.
  - A write to that word is dropped.
  - range_err is set and stays set until reset.
  - The in-range words of the same request proceed normally.
- Array-busy definition: busy = OR of all A/D/B read valids and all C write valids in the current cycle.
- Host handshake:
  - host_req_ready = ~busy & ~reset (combinational).
  - A transfer occurs when host_req_valid & host_req_ready.
  - Host store: writes mem[host_req_addr] at that edge.
  - Host load: host_resp_valid = 1 on the next cycle only, with host_resp_rdata = mem[addr] (old data at the request edge).
  - Back-to-back host requests are allowed every cycle.
  - While busy, host requests stall; the host holds valid and the request fields.
- Host out of range: a host access with addr ≥ DEPTH sets range_err. A store is dropped; a load returns 0 with resp_valid still asserted.
- Host state machine, two states:
  - IDLE → RESP on an accepted load.
  - RESP → RESP on a further accepted load.
  - RESP → IDLE otherwise.
- Reset mid-operation:
  - All pending read data and responses are discarded.
  - Memory is cleared.
  - No write from the reset cycle is committed.

Optional Feature:
- Macro: SCRATCHPAD_STATS_EN.
- Defined: adds outputs stat_reads, stat_writes and stat_stalls, each 32 bits, reset to 0.
  - stat_reads increments by the number of valid read lanes per cycle.
  - stat_writes increments by the number of valid C lanes plus accepted host stores.
  - stat_stalls increments on each cycle with host_req_valid & ~host_req_ready.
  - All counters saturate at 2^32-1.
- Undefined: these ports and all counter logic are absent.

Decomposition:
- Shared package sys_array_pkg holds:
  - the host state enum (HOST_IDLE, HOST_RESP);
  - the READ_LATENCY legality check constant;
  - a function that computes the in-range predicate.
- One natural sub-module: scratchpad_read_lane. It turns one base address plus valid into TILEUNITS words with the range check and optional output register. It is instantiated 3 x MESHUNITS times.

Test Plan:
- Host fill and readback: host stores mem[k] = k+100 for k = 0..15, then loads addr 5 → host_resp_valid one cycle later with rdata = 105.
- Array read, READ_LATENCY = 1: A_read_valid[1] = 1, addr = 4 → next cycle A[1][0] = 104 and A[1][1] = 105; A[0] stays 0.
- C write collision: lanes 0 and 1 both write addr 8 in the same cycle with C[0][0] = 7 and C[1][0] = 9 → a host load of addr 8 returns 9.
- Host stall: array busy for 3 cycles while host_req_valid is held → host_req_ready = 0 for those 3 cycles and the store commits on cycle 4. With SCRATCHPAD_STATS_EN, stat_stalls = 3.
- Out of range at DEPTH = 256: B read with addr = 255, TILEUNITS = 2 → B[i][0] = mem[255], B[i][1] = 0, and range_err rises and stays 1.
- Reset mid-load: accept a host load, then assert reset on the next cycle → host_resp_valid = 0, memory reads back 0, range_err = 0.
